// File: rtl/phv_parser_if.sv
// AXI-Stream packet input bundle for the PHV parser.
interface phv_parser_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/phv_parser.sv
// Ingress parser: forwards beats to the packet FIFO, extracts header fields into one PHV per packet.
// Optional PHV_PARSER_VLAN_CHECK_EN: non-802.1Q packets (bytes 12,13 != 81 00) use vlan_id 0.
module phv_parser #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_PKT_VEC_WIDTH    = 1124
) (
  input  logic                            clk,
  input  logic                            areset,
  phv_parser_if.slave                     s_axis,
  output logic [C_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
  output logic                            pkt_fifo_tlast,
  output logic                            pkt_fifo_wr_en,
  input  logic                            pkt_fifo_full,
  output logic [C_PKT_VEC_WIDTH-1:0]      phv_fifo_in,
  output logic                            phv_fifo_wr_en,
  input  logic                            phv_fifo_full,
  input  logic                            ctrl_wr_en,
  input  logic [3:0]                      ctrl_wr_addr,
  input  logic [159:0]                    ctrl_wr_data
);
  typedef enum logic [2:0] {IDLE, BUF, LOOKUP, EXTRACT, EMIT, PASS} state_t;

  state_t                          state_reg;
  logic [1:0]                      cnt_reg;
  logic                            tlast_seen_reg;
  logic [159:0]                    table_mem [16];
  logic [159:0]                    actions_reg;
  logic [C_AXIS_DATA_WIDTH-1:0]    buf_reg [4];
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_reg;
  logic [11:0]                     vlan_reg;
  logic [C_PKT_VEC_WIDTH-1:0]      phv_reg;
  logic [C_PKT_VEC_WIDTH-1:0]      phv_next;
  logic [4*C_AXIS_DATA_WIDTH+47:0] buf_flat;
  logic [11:0]                     vlan_in;
  logic [15:0]                     act;
  logic [9:0]                      bit_base;
  logic                            accept;

  assign s_axis.tready = (state_reg == IDLE || state_reg == BUF || state_reg == PASS)
                         && !pkt_fifo_full && !areset;
  assign accept         = s_axis.tvalid && s_axis.tready;
  assign phv_fifo_wr_en = (state_reg == EMIT) && !phv_fifo_full;
  assign phv_fifo_in    = phv_reg;

  // Zero tail lets a 6B field at offset 127 read past the last buffered byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_flat
      assign buf_flat[C_AXIS_DATA_WIDTH*gi +: C_AXIS_DATA_WIDTH] = buf_reg[gi];
    end
  endgenerate
  assign buf_flat[4*C_AXIS_DATA_WIDTH +: 48] = '0;

  always_comb begin
    vlan_in = {s_axis.tdata[115:112], s_axis.tdata[127:120]};
`ifdef PHV_PARSER_VLAN_CHECK_EN
    if (s_axis.tdata[103:96] != 8'h81 || s_axis.tdata[111:104] != 8'h00)
      vlan_in = '0;
`endif
  end

  // Action 0 sits in the top 16 bits; ascending order makes the higher index win.
  always_comb begin
    phv_next          = '0;
    act               = '0;
    bit_base          = '0;
    phv_next[127:0]   = tuser_reg;
    phv_next[140:129] = vlan_reg;
    for (int k = 0; k < 10; k++) begin
      act      = actions_reg[144-16*k +: 16];
      bit_base = {act[12:6], 3'b000};
      if (act[0]) begin
        case (act[5:4])
          2'b01:   phv_next[356 + 16*act[3:1] +: 16] = buf_flat[bit_base +: 16];
          2'b10:   phv_next[484 + 32*act[3:1] +: 32] = buf_flat[bit_base +: 32];
          2'b11:   phv_next[740 + 48*act[3:1] +: 48] = buf_flat[bit_base +: 48];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 16; i++) table_mem[i] <= '0;
    end else if (ctrl_wr_en) begin
      table_mem[ctrl_wr_addr] <= ctrl_wr_data;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      tlast_seen_reg <= 1'b0;
      actions_reg    <= '0;
      for (int i = 0; i < 4; i++) buf_reg[i] <= '0;
      tuser_reg      <= '0;
      vlan_reg       <= '0;
      phv_reg        <= '0;
      pkt_fifo_tdata <= '0;
      pkt_fifo_tkeep <= '0;
      pkt_fifo_tuser <= '0;
      pkt_fifo_tlast <= 1'b0;
      pkt_fifo_wr_en <= 1'b0;
    end else begin
      pkt_fifo_wr_en <= accept;
      if (accept) begin
        pkt_fifo_tdata <= s_axis.tdata;
        pkt_fifo_tkeep <= s_axis.tkeep;
        pkt_fifo_tuser <= s_axis.tuser;
        pkt_fifo_tlast <= s_axis.tlast;
      end
      case (state_reg)
        IDLE: if (accept) begin
          buf_reg[0]     <= s_axis.tdata;
          for (int i = 1; i < 4; i++) buf_reg[i] <= '0;
          tuser_reg      <= s_axis.tuser;
          vlan_reg       <= vlan_in;
          tlast_seen_reg <= s_axis.tlast;
          cnt_reg        <= 2'd1;
          state_reg      <= s_axis.tlast ? LOOKUP : BUF;
        end
        BUF: if (accept) begin
          buf_reg[cnt_reg] <= s_axis.tdata;
          cnt_reg          <= cnt_reg + 2'd1;
          tlast_seen_reg   <= s_axis.tlast;
          if (s_axis.tlast || cnt_reg == 2'd3) state_reg <= LOOKUP;
        end
        LOOKUP: begin
          actions_reg <= table_mem[vlan_reg[7:4]];
          state_reg   <= EXTRACT;
        end
        EXTRACT: begin
          phv_reg   <= phv_next;
          state_reg <= EMIT;
        end
        EMIT: if (!phv_fifo_full) state_reg <= tlast_seen_reg ? IDLE : PASS;
        PASS: if (accept && s_axis.tlast) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phv_parser.sv
// Directed self-checking bench for phv_parser.
module tb_phv_parser;
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  phv_parser_if s_axis ();
  logic [255:0]  pkt_fifo_tdata;
  logic [31:0]   pkt_fifo_tkeep;
  logic [127:0]  pkt_fifo_tuser;
  logic          pkt_fifo_tlast, pkt_fifo_wr_en, pkt_fifo_full;
  logic [1123:0] phv_fifo_in;
  logic          phv_fifo_wr_en, phv_fifo_full;
  logic          ctrl_wr_en;
  logic [3:0]    ctrl_wr_addr;
  logic [159:0]  ctrl_wr_data;

  phv_parser dut (
    .clk(clk), .areset(areset), .s_axis(s_axis),
    .pkt_fifo_tdata(pkt_fifo_tdata), .pkt_fifo_tkeep(pkt_fifo_tkeep),
    .pkt_fifo_tuser(pkt_fifo_tuser), .pkt_fifo_tlast(pkt_fifo_tlast),
    .pkt_fifo_wr_en(pkt_fifo_wr_en), .pkt_fifo_full(pkt_fifo_full),
    .phv_fifo_in(phv_fifo_in), .phv_fifo_wr_en(phv_fifo_wr_en),
    .phv_fifo_full(phv_fifo_full), .ctrl_wr_en(ctrl_wr_en),
    .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data)
  );

  typedef struct {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  k;
    logic         l;
    int           c;
  } beat_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  beat_t pkt_q[$];
  logic [1123:0] phv_q[$];
  int phv_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (pkt_fifo_wr_en === 1'b1) begin
      b.d = pkt_fifo_tdata; b.u = pkt_fifo_tuser; b.k = pkt_fifo_tkeep;
      b.l = pkt_fifo_tlast; b.c = cyc;
      pkt_q.push_back(b);
    end
    if (phv_fifo_wr_en === 1'b1) begin
      phv_q.push_back(phv_fifo_in);
      phv_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [255:0] make_beat(input int seed, input int b, input logic [31:0] hdr);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(seed + b*32 + i);
    if (b == 0) begin
      d[96 +: 8] = hdr[31:24]; d[104 +: 8] = hdr[23:16];
      d[112 +: 8] = hdr[15:8]; d[120 +: 8] = hdr[7:0];
    end
    return d;
  endfunction

  function automatic logic [159:0] put_action(input logic [159:0] w, input int k, input logic [15:0] a);
    logic [159:0] r;
    r = w;
    r[144-16*k +: 16] = a;
    return r;
  endfunction

  function automatic logic [1123:0] base_phv(input logic [127:0] u, input logic [11:0] v);
    logic [1123:0] p;
    p = '0;
    p[127:0] = u;
    p[129 +: 12] = v;
    return p;
  endfunction

  task automatic write_table(input logic [3:0] a, input logic [159:0] d);
    ctrl_wr_en = 1'b1; ctrl_wr_addr = a; ctrl_wr_data = d;
    @(posedge clk); #1;
    ctrl_wr_en = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic last, output int acc);
    s_axis.tdata = d; s_axis.tkeep = '1; s_axis.tuser = u; s_axis.tlast = last; s_axis.tvalid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (s_axis.tready === 1'b1) acc = cyc;
      @(posedge clk); #1;
    end
    s_axis.tvalid = 1'b0;
    if (acc < 0) begin
      total_cnt++;
      $display("FAIL accept_timeout got=no_handshake exp=handshake");
    end
  endtask

  task automatic wait_phv(input int n);
    for (int i = 0; i < 60 && phv_q.size() < n; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pkt_q.delete(); phv_q.delete(); phv_cyc_q.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tuser = '0; s_axis.tlast = 1'b0;
    pkt_fifo_full = 1'b0; phv_fifo_full = 1'b0;
    ctrl_wr_en = 1'b0; ctrl_wr_addr = '0; ctrl_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (s_axis.tready !== 1'b0) $display("FAIL rst_tready got=%b exp=0", s_axis.tready); else pass_cnt++;
    total_cnt++; if (pkt_fifo_wr_en !== 1'b0) $display("FAIL rst_pkt_wr got=%b exp=0", pkt_fifo_wr_en); else pass_cnt++;
    total_cnt++; if (phv_fifo_wr_en !== 1'b0) $display("FAIL rst_phv_wr got=%b exp=0", phv_fifo_wr_en); else pass_cnt++;
    total_cnt++; if (phv_fifo_in !== '0) $display("FAIL rst_phv_in got=nonzero exp=0"); else pass_cnt++;
    total_cnt++; if (pkt_fifo_tdata !== '0) $display("FAIL rst_pkt_tdata got=%h exp=0", pkt_fifo_tdata); else pass_cnt++;
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    total_cnt++; if (s_axis.tready !== 1'b1) $display("FAIL idle_tready got=%b exp=1", s_axis.tready); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    logic [255:0] d; logic [127:0] u; logic [1123:0] exp_phv, got; int t;
    write_table(4'd1, put_action('0, 0, 16'h0391));
    clear_q();
    d = make_beat(0, 0, 32'h81000010);
    u = 128'hA5A5_0001_0203_0405_0607_0809_0A0B_5A5A;
    send_beat(d, u, 1'b1, t);
    wait_phv(1);
    exp_phv = base_phv(u, 12'h010);
    exp_phv[356 +: 16] = 16'h1000;
    got = (phv_q.size() > 0) ? phv_q[0] : 'x;
    total_cnt++; if (phv_q.size() != 1) $display("FAIL single_phv_count got=%0d exp=1", phv_q.size()); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (got[c*281 +: 281] !== exp_phv[c*281 +: 281])
        $display("FAIL single_phv[%0d] got=%h exp=%h", c, got[c*281 +: 281], exp_phv[c*281 +: 281]);
      else pass_cnt++;
    end
    total_cnt++;
    if (phv_cyc_q.size() < 1 || phv_cyc_q[0] != t + 3)
      $display("FAIL single_phv_cycle got=%0d exp=%0d", (phv_cyc_q.size() > 0) ? phv_cyc_q[0] - t : -1, 3);
    else pass_cnt++;
    total_cnt++;
    if (pkt_q.size() != 1 || pkt_q[0].d !== d || pkt_q[0].u !== u || pkt_q[0].l !== 1'b1 || pkt_q[0].k !== '1 || pkt_q[0].c != t + 1)
      $display("FAIL single_pkt_beat got=count%0d exp=count1_unchanged_at_T+1", pkt_q.size());
    else pass_cnt++;
  endtask

  task automatic test_multi_beat();
    logic [255:0] d [5]; logic [127:0] u; logic [1123:0] exp_phv, got; int t [5];
    write_table(4'd2, put_action('0, 0, 16'h1E3B));
    clear_q();
    u = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    for (int b = 0; b < 5; b++) d[b] = make_beat(0, b, 32'h81000020);
    for (int b = 0; b < 5; b++) send_beat(d[b], u, (b == 4), t[b]);
    wait_phv(1);
    exp_phv = base_phv(u, 12'h020);
    exp_phv[980 +: 48] = 48'h7D7C_7B7A_7978;
    got = (phv_q.size() > 0) ? phv_q[0] : 'x;
    total_cnt++; if (phv_q.size() != 1) $display("FAIL multi_phv_count got=%0d exp=1", phv_q.size()); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (got[c*281 +: 281] !== exp_phv[c*281 +: 281])
        $display("FAIL multi_phv[%0d] got=%h exp=%h", c, got[c*281 +: 281], exp_phv[c*281 +: 281]);
      else pass_cnt++;
    end
    total_cnt++;
    if (phv_cyc_q.size() < 1 || phv_cyc_q[0] != t[3] + 3)
      $display("FAIL multi_phv_cycle got=%0d exp=3", (phv_cyc_q.size() > 0) ? phv_cyc_q[0] - t[3] : -1);
    else pass_cnt++;
    total_cnt++; if (t[4] != t[3] + 4) $display("FAIL multi_stall got=%0d exp=4", t[4] - t[3]); else pass_cnt++;
    total_cnt++; if (pkt_q.size() != 5) $display("FAIL multi_pkt_count got=%0d exp=5", pkt_q.size()); else pass_cnt++;
    for (int b = 0; b < 5 && b < pkt_q.size(); b++) begin
      total_cnt++;
      if (pkt_q[b].d !== d[b] || pkt_q[b].l !== (b == 4))
        $display("FAIL multi_pkt_beat%0d got=%h/%b exp=%h/%b", b, pkt_q[b].d, pkt_q[b].l, d[b], (b == 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_priority();
    logic [255:0] d; logic [127:0] u; logic [159:0] w; logic [1123:0] exp_phv, got; int t;
    w = put_action('0, 2, 16'h0127);
    w = put_action(w, 7, 16'h0527);
    w = put_action(w, 9, 16'h1F93);
    write_table(4'd3, w);
    clear_q();
    d = make_beat(8'h40, 0, 32'h81000030);
    u = 128'hC0FF_EE00_0000_0000_0000_0000_0000_0003;
    send_beat(d, u, 1'b1, t);
    wait_phv(1);
    exp_phv = base_phv(u, 12'h030);
    exp_phv[580 +: 32] = 32'h5756_5554;
    got = (phv_q.size() > 0) ? phv_q[0] : 'x;
    total_cnt++; if (got[580 +: 32] !== 32'h5756_5554) $display("FAIL prio_container got=%h exp=57565554", got[580 +: 32]); else pass_cnt++;
    total_cnt++; if (got[372 +: 16] !== 16'h0) $display("FAIL prio_beyond_pkt got=%h exp=0000", got[372 +: 16]); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (got[c*281 +: 281] !== exp_phv[c*281 +: 281])
        $display("FAIL prio_phv[%0d] got=%h exp=%h", c, got[c*281 +: 281], exp_phv[c*281 +: 281]);
      else pass_cnt++;
    end
  endtask

  task automatic test_phv_full();
    logic [255:0] d; logic [127:0] u; logic [1123:0] exp_phv, got; int t, bad_rdy, bad_wr, bad_hold;
    clear_q();
    phv_fifo_full = 1'b1;
    d = make_beat(8'h10, 0, 32'h81000010);
    u = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    exp_phv = base_phv(u, 12'h010);
    exp_phv[356 +: 16] = 16'h1000;
    s_axis.tvalid = 1'b0;
    send_beat(d, u, 1'b1, t);
    bad_rdy = 0; bad_wr = 0; bad_hold = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (s_axis.tready !== 1'b0) bad_rdy++;
      if (phv_fifo_wr_en !== 1'b0) bad_wr++;
      if (i >= 3 && phv_fifo_in !== exp_phv) bad_hold++;
    end
    @(posedge clk); #1;
    phv_fifo_full = 1'b0;
    wait_phv(1);
    got = (phv_q.size() > 0) ? phv_q[0] : 'x;
    total_cnt++; if (bad_rdy != 0) $display("FAIL full_tready got=%0d_high exp=0_high", bad_rdy); else pass_cnt++;
    total_cnt++; if (bad_wr != 0) $display("FAIL full_wr_blocked got=%0d_writes exp=0", bad_wr); else pass_cnt++;
    total_cnt++; if (bad_hold != 0) $display("FAIL full_phv_hold got=%0d_changes exp=0", bad_hold); else pass_cnt++;
    total_cnt++; if (phv_q.size() != 1) $display("FAIL full_phv_count got=%0d exp=1", phv_q.size()); else pass_cnt++;
    total_cnt++;
    if (phv_cyc_q.size() < 1 || phv_cyc_q[0] != t + 13)
      $display("FAIL full_phv_cycle got=%0d exp=13", (phv_cyc_q.size() > 0) ? phv_cyc_q[0] - t : -1);
    else pass_cnt++;
    total_cnt++; if (got !== exp_phv) $display("FAIL full_phv_value got=%h exp=%h", got[127:0], exp_phv[127:0]); else pass_cnt++;
  endtask

  task automatic test_non_vlan();
    logic [255:0] d; logic [127:0] u; logic [1123:0] exp_phv, got; int t;
    write_table(4'd0, put_action('0, 0, 16'h001F));
    clear_q();
    d = make_beat(8'h80, 0, 32'h08000030);
    u = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
`ifdef PHV_PARSER_VLAN_CHECK_EN
    exp_phv = base_phv(u, 12'h000);
    exp_phv[468 +: 16] = 16'h8180;
`else
    exp_phv = base_phv(u, 12'h030);
    exp_phv[580 +: 32] = 32'h9796_9594;
`endif
    send_beat(d, u, 1'b1, t);
    wait_phv(1);
    got = (phv_q.size() > 0) ? phv_q[0] : 'x;
    total_cnt++; if (got[129 +: 12] !== exp_phv[129 +: 12]) $display("FAIL nonvlan_vid got=%h exp=%h", got[129 +: 12], exp_phv[129 +: 12]); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (got[c*281 +: 281] !== exp_phv[c*281 +: 281])
        $display("FAIL nonvlan_phv[%0d] got=%h exp=%h", c, got[c*281 +: 281], exp_phv[c*281 +: 281]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [255:0] d; logic [127:0] u; logic [159:0] w; logic [1123:0] exp_phv, got; int t;
    w = put_action('0, 0, 16'h0391);
    w = put_action(w, 1, 16'h0A15);
    write_table(4'd1, w);
    u = 128'h7777_0000_0000_0000_0000_0000_0000_7777;
    send_beat(make_beat(8'hC0, 0, 32'h81000010), u, 1'b0, t);
    send_beat(make_beat(8'hC0, 1, 32'h0), u, 1'b0, t);
    areset = 1'b1;
    @(negedge clk);
    total_cnt++; if (s_axis.tready !== 1'b0) $display("FAIL midrst_tready got=%b exp=0", s_axis.tready); else pass_cnt++;
    total_cnt++; if (pkt_fifo_wr_en !== 1'b0) $display("FAIL midrst_pkt_wr got=%b exp=0", pkt_fifo_wr_en); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    write_table(4'd1, w);
    clear_q();
    d = make_beat(8'h20, 0, 32'h81000010);
    u = 128'h0000_1234_0000_0000_0000_0000_0000_0000;
    send_beat(d, u, 1'b1, t);
    wait_phv(1);
    exp_phv = base_phv(u, 12'h010);
    exp_phv[356 +: 16] = 16'h1000;
    got = (phv_q.size() > 0) ? phv_q[0] : 'x;
    total_cnt++; if (phv_q.size() != 1) $display("FAIL midrst_phv_count got=%0d exp=1", phv_q.size()); else pass_cnt++;
    total_cnt++; if (got[388 +: 16] !== 16'h0) $display("FAIL midrst_stale got=%h exp=0000", got[388 +: 16]); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (got[c*281 +: 281] !== exp_phv[c*281 +: 281])
        $display("FAIL midrst_phv[%0d] got=%h exp=%h", c, got[c*281 +: 281], exp_phv[c*281 +: 281]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_priority();
    test_phv_full();
    test_non_vlan();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
